// File: rtl/pipe_pkg.sv
// Shared constants and types for the instruction fetch pipeline.
package pipe_pkg;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds, flush or an idle cycle inserts a NOP
// bubble (PC+4 kept), load captures a delivered instruction.
import pipe_pkg::*;

module if_id_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= INSTR_W'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      if (load && !flush) begin
        instr    <= load_instr;
        pc_plus4 <= load_pc4;
        valid    <= 1'b1;
      end else begin
        instr    <= INSTR_W'(NOP_INSTR);
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, stall-hold buffer,
// branch redirect with in-flight response drain, and the IF/ID register.
import pipe_pkg::*;

module fetch_stage #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [ADDR_W-1:0]  PCBranchD,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               ValidD
);

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pcf_n, addr_n;
  logic               req_n;
  logic [INSTR_W-1:0] hold_instr, hold_instr_n;
  logic [ADDR_W-1:0]  hold_pc4, hold_pc4_n;
  logic               redirect;
  logic               d_load;
  logic [INSTR_W-1:0] d_instr;
  logic [ADDR_W-1:0]  d_pc4;
  logic [ADDR_W-1:0]  pc_inc;

  // A stalled decode stage cannot act on its branch, so StallD masks PCSrcD.
  assign redirect = PCSrcD & ~StallD;
  assign pc_inc   = PCF + ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      PCF        <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
      hold_instr <= INSTR_W'(NOP_INSTR);
      hold_pc4   <= '0;
    end else begin
      state      <= state_n;
      PCF        <= pcf_n;
      imem_addr  <= addr_n;
      imem_req   <= req_n;
      hold_instr <= hold_instr_n;
      hold_pc4   <= hold_pc4_n;
    end
  end

  always_comb begin
    state_n      = state;
    pcf_n        = PCF;
    hold_instr_n = hold_instr;
    hold_pc4_n   = hold_pc4;
    d_load       = 1'b0;
    d_instr      = imem_rdata;
    d_pc4        = imem_addr + ADDR_W'(PC_INC);

    unique case (state)
      S_BOOT: begin
        state_n = S_REQ;
        if (redirect) pcf_n = PCBranchD;
      end
      S_REQ: begin
        if (redirect) begin
          pcf_n = PCBranchD;
          if (!imem_ready) state_n = S_DRAIN;
        end else if (imem_ready) begin
          if (StallD) begin
            hold_instr_n = imem_rdata;
            hold_pc4_n   = imem_addr + ADDR_W'(PC_INC);
            state_n      = S_HOLD;
          end else begin
            d_load = 1'b1;
            if (!StallF) pcf_n = pc_inc;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pcf_n   = PCBranchD;
          state_n = S_REQ;
        end else if (!StallD) begin
          d_load  = 1'b1;
          d_instr = hold_instr;
          d_pc4   = hold_pc4;
          if (!StallF) pcf_n = pc_inc;
          state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        // The old request must complete before the redirected PC is fetched.
        if (redirect) pcf_n = PCBranchD;
        if (imem_ready) state_n = S_REQ;
      end
      default: state_n = S_BOOT;
    endcase

    addr_n = (state_n == S_DRAIN) ? imem_addr : pcf_n;
    req_n  = (state_n == S_REQ) || (state_n == S_DRAIN);
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (StallD),
    .flush      (redirect),
    .load       (d_load),
    .load_instr (d_instr),
    .load_pc4   (d_pc4),
    .instr      (InstrD),
    .pc_plus4   (PCPlus4D),
    .valid      (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a program-order scoreboard with a variable-latency memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;

  int unsigned tests = 0;
  int unsigned fails = 0;

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    PCBranchD = '0; imem_ready = 1'b0; imem_rdata = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Zero-wait memory until a request to target is presented, then leave ready low.
  task automatic run_to(input logic [31:0] target);
    int n = 0;
    while (!(imem_req && imem_addr == target) && n < 64) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(imem_addr);
      cyc();
      n++;
    end
    imem_ready = 1'b0;
    tests++;
    if (!(imem_req && imem_addr == target)) begin
      fails++; $display("FAIL run_to: addr %h req %b, required addr %h", imem_addr, imem_req, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    repeat (2) cyc();
    tests++; if (PCF !== 32'h0)       begin fails++; $display("FAIL reset_pcf: got %h want 0", PCF); end
    tests++; if (imem_req !== 1'b0)   begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    tests++; if (ValidD !== 1'b0)     begin fails++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    tests++; if (InstrD !== 32'h0)    begin fails++; $display("FAIL reset_instr: got %h want 0", InstrD); end
    tests++; if (PCPlus4D !== 32'h0)  begin fails++; $display("FAIL reset_pc4: got %h want 0", PCPlus4D); end
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL boot_req: got %b want 0", imem_req); end
    cyc();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ValidD !== 1'b0) begin
      fails++; $display("FAIL first_req: req %b addr %h valid %b, want 1 0 0", imem_req, imem_addr, ValidD);
    end
    for (int k = 0; k < 3; k++) begin
      imem_rdata = mem_word(imem_addr);
      cyc();
      tests++;
      if (imem_addr !== 32'(4 * (k + 1)) || InstrD !== mem_word(32'(4 * k)) ||
          PCPlus4D !== 32'(4 * (k + 1)) || ValidD !== 1'b1) begin
        fails++; $display("FAIL back_to_back[%0d]: addr %h instr %h pc4 %h valid %b", k, imem_addr, InstrD, PCPlus4D, ValidD);
      end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_wait();
    do_reset();
    run_to(32'h10);
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1 || ValidD !== 1'b0) begin
        fails++; $display("FAIL wait[%0d]: addr %h req %b valid %b, want 10 1 0", k, imem_addr, imem_req, ValidD);
      end
    end
    imem_ready = 1'b1; imem_rdata = 32'hA5A5_0010;
    cyc();
    imem_ready = 1'b0;
    tests++;
    if (InstrD !== 32'hA5A5_0010 || PCPlus4D !== 32'h14 || ValidD !== 1'b1) begin
      fails++; $display("FAIL wait_deliver: instr %h pc4 %h valid %b, want a5a50010 14 1", InstrD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    run_to(32'hC);
    StallF = 1'b1; StallD = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ready = 1'b0; imem_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (InstrD !== mem_word(32'h8) || PCPlus4D !== 32'hC || ValidD !== 1'b1 ||
          imem_req !== 1'b0 || PCF !== 32'hC) begin
        fails++; $display("FAIL hold[%0d]: instr %h pc4 %h valid %b req %b pcf %h", k, InstrD, PCPlus4D, ValidD, imem_req, PCF);
      end
      if (k == 0) cyc();
    end
    StallF = 1'b0; StallD = 1'b0;
    cyc();
    tests++;
    if (InstrD !== 32'hDEAD_BEEF || PCPlus4D !== 32'h10 || ValidD !== 1'b1 ||
        PCF !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      fails++; $display("FAIL hold_release: instr %h pc4 %h valid %b pcf %h req %b addr %h", InstrD, PCPlus4D, ValidD, PCF, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    run_to(32'h20);
    PCSrcD = 1'b1; PCBranchD = 32'h100;
    cyc();
    PCSrcD = 1'b0;
    tests++;
    if (PCF !== 32'h100 || imem_addr !== 32'h20 || imem_req !== 1'b1 || ValidD !== 1'b0) begin
      fails++; $display("FAIL drain_enter: pcf %h addr %h req %b valid %b", PCF, imem_addr, imem_req, ValidD);
    end
    cyc();
    tests++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL drain_addr_stable: got %h want 20", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h2020_2020;
    cyc();
    tests++;
    if (ValidD !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      fails++; $display("FAIL drain_discard: valid %b addr %h req %b, want 0 100 1", ValidD, imem_addr, imem_req);
    end
    imem_rdata = mem_word(32'h100);
    cyc();
    imem_ready = 1'b0;
    tests++;
    if (InstrD !== mem_word(32'h100) || PCPlus4D !== 32'h104 || ValidD !== 1'b1) begin
      fails++; $display("FAIL drain_target: instr %h pc4 %h valid %b", InstrD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_redirect_corner();
    do_reset();
    run_to(32'h8);
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h200;
    cyc();
    tests++;
    if (PCF !== 32'h8 || imem_addr !== 32'h8 || InstrD !== mem_word(32'h4) || ValidD !== 1'b1) begin
      fails++; $display("FAIL masked_branch: pcf %h addr %h instr %h valid %b", PCF, imem_addr, InstrD, ValidD);
    end
    StallF = 1'b0; StallD = 1'b0; PCBranchD = 32'h300;
    imem_ready = 1'b1; imem_rdata = mem_word(32'h8);
    cyc();
    PCSrcD = 1'b0;
    tests++;
    if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h8 || PCF !== 32'h300 || imem_addr !== 32'h300) begin
      fails++; $display("FAIL ready_redirect: valid %b instr %h pc4 %h pcf %h addr %h", ValidD, InstrD, PCPlus4D, PCF, imem_addr);
    end
    imem_rdata = mem_word(32'h300);
    cyc();
    imem_ready = 1'b0;
    tests++;
    if (InstrD !== mem_word(32'h300) || PCPlus4D !== 32'h304 || ValidD !== 1'b1) begin
      fails++; $display("FAIL redirect_target: instr %h pc4 %h valid %b", InstrD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_to(32'h4);
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'h0BAD_0004;
    cyc();
    PCSrcD = 1'b0;
    imem_rdata = mem_word(32'hFFFF_FFFC);
    cyc();
    imem_ready = 1'b0;
    tests++;
    if (InstrD !== mem_word(32'hFFFF_FFFC) || PCPlus4D !== 32'h0 || PCF !== 32'h0 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL pc_wrap: instr %h pc4 %h pcf %h addr %h", InstrD, PCPlus4D, PCF, imem_addr);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    run_to(32'h8);
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    cyc();
    PCSrcD = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (PCF !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b0 ||
        ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
      fails++; $display("FAIL async_reset: pcf %h addr %h req %b valid %b instr %h pc4 %h", PCF, imem_addr, imem_req, ValidD, InstrD, PCPlus4D);
    end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    tests++;
    if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL stale_ready_boot: valid %b req %b addr %h", ValidD, imem_req, imem_addr);
    end
    imem_ready = 1'b0;
    cyc();
    tests++;
    if (ValidD !== 1'b0 || PCF !== 32'h0) begin
      fails++; $display("FAIL stale_ready_after: valid %b pcf %h", ValidD, PCF);
    end
  endtask

  // Scoreboard: PCF always names the next program-order instruction not yet
  // delivered; each delivery must carry that instruction and its PC+4.
  task automatic test_random();
    logic [31:0] exp_pc, prv_instr, prv_pc4, paddr;
    logic        prv_valid, st, redir, pend;
    int          wait_cnt, deliveries;
    do_reset();
    exp_pc = 32'h0; prv_instr = 32'h0; prv_pc4 = 32'h0; prv_valid = 1'b0;
    wait_cnt = 0; deliveries = 0;
    for (int c = 0; c < 1500; c++) begin
      st = ($urandom_range(0, 7) == 0);
      StallF = st; StallD = st;
      PCSrcD = (c != 0) && ($urandom_range(0, 15) == 0);
      PCBranchD = $urandom & 32'hFFFF_FFFC;
      if (imem_req && wait_cnt == 0) begin
        imem_ready = 1'b1; imem_rdata = mem_word(imem_addr);
        wait_cnt = $urandom_range(0, 2);
      end else begin
        imem_ready = 1'b0; imem_rdata = $urandom;
        if (imem_req) wait_cnt--;
      end
      redir = PCSrcD && !StallD;
      pend  = imem_req && !imem_ready;
      paddr = imem_addr;
      cyc();
      tests++;
      if (st) begin
        if (InstrD !== prv_instr || PCPlus4D !== prv_pc4 || ValidD !== prv_valid) begin
          fails++; $display("FAIL rand_stall c%0d: instr %h pc4 %h valid %b, want %h %h %b", c, InstrD, PCPlus4D, ValidD, prv_instr, prv_pc4, prv_valid);
        end
      end else if (redir) begin
        exp_pc = PCBranchD;
        if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== prv_pc4) begin
          fails++; $display("FAIL rand_flush c%0d: instr %h pc4 %h valid %b", c, InstrD, PCPlus4D, ValidD);
        end
        prv_instr = 32'h0; prv_valid = 1'b0;
      end else if (ValidD === 1'b1) begin
        if (InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
          fails++; $display("FAIL rand_deliver c%0d: instr %h pc4 %h, want %h %h", c, InstrD, PCPlus4D, mem_word(exp_pc), exp_pc + 32'd4);
        end
        prv_instr = mem_word(exp_pc); prv_pc4 = exp_pc + 32'd4; prv_valid = 1'b1;
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        if (InstrD !== 32'h0 || PCPlus4D !== prv_pc4) begin
          fails++; $display("FAIL rand_bubble c%0d: instr %h pc4 %h, want 0 %h", c, InstrD, PCPlus4D, prv_pc4);
        end
        prv_instr = 32'h0; prv_valid = 1'b0;
      end
      tests++;
      if (PCF !== exp_pc) begin
        fails++; $display("FAIL rand_pcf c%0d: got %h want %h", c, PCF, exp_pc);
      end
      if (pend) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== paddr) begin
          fails++; $display("FAIL rand_req_stable c%0d: req %b addr %h want 1 %h", c, imem_req, imem_addr, paddr);
        end
      end
    end
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; imem_ready = 1'b0;
    tests++;
    if (deliveries < 100) begin
      fails++; $display("FAIL rand_throughput: %0d deliveries, want at least 100", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_wait();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_corner();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
